sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO; next generation of the SPI datapath FIFO. Generalised in width and depth, with programmable almost-full/almost-empty thresholds, a fill-level output, and read/write pass-through when full. Sits between the SPI slave shift logic and the RAM/control side; the existing FIFO interface signal set is kept, plus count.

---
 rtl/sync_fifo_param_pkg.sv | 22 ++
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param_mem.sv | 23 ++
 rtl/sync_fifo_param.sv | 96 +++++++++
 tb/tb_sync_fifo_param.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_pkg: shared constants, count-width helper and status bundle
// for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic overflow;
    logic underflow;
    logic wr_ack;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read/status signal bundle of the FIFO.
// master drives requests, slave is the FIFO side.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = cnt_width(DEPTH)
);
  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic [CW-1:0]    count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// fifo_mem: DEPTH x WIDTH register array, synchronous write,
// combinational read address.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised FIFO with thresholds and pass-through.
// Define FIFO_FWFT_EN for first-word fall-through output.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic clk,
  input logic rst,
  sync_fifo_param_if.slave bus
);
  localparam int CW = cnt_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == FULL_C);
  assign empty = (count == '0);
  assign rd_ok = bus.rd_en && !empty;
  assign wr_ok = bus.wr_en && (!full || bus.rd_en);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // pointers and occupancy; wrap is explicit, no power-of-two needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (rd_ok)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // one-cycle handshake pulses for the previous request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.wr_ack    <= wr_ok;
      bus.overflow  <= bus.wr_en && !wr_ok;
      bus.underflow <= bus.rd_en && empty;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : rdata;
`else
  // registered read: head word captured on each accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        bus.data_out <= '0;
    else if (rd_ok) bus.data_out <= rdata;
  end
`endif

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count >= AF_C);
  assign bus.almostempty = (count <= AE_C);
  assign bus.count       = count;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model scoreboard plus directed literal checks.
// Define FIFO_FWFT_EN to check the fall-through build.
module tb_sync_fifo_param;
  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_fifo_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] q[$];
  logic [W-1:0] e_dout;
  logic         e_ack;
  logic         e_ovf;
  logic         e_unf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: FIFO as a queue, rules applied at each clock edge
  always @(posedge clk or posedge rst) begin
    bit fm, em, rok, wok;
    if (rst) begin
      q.delete();
      e_dout = '0;
      e_ack  = 1'b0;
      e_ovf  = 1'b0;
      e_unf  = 1'b0;
    end else begin
      fm  = (q.size() == D);
      em  = (q.size() == 0);
      rok = bus.rd_en && !em;
      wok = bus.wr_en && (!fm || bus.rd_en);
      e_ack = wok;
      e_ovf = bus.wr_en && !wok;
      e_unf = bus.rd_en && em;
      if (rok) begin
`ifndef FIFO_FWFT_EN
        e_dout = q[0];
`endif
        void'(q.pop_front());
      end
      if (wok) q.push_back(bus.data_in);
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    int n;
    int exp_d;
    n = q.size();
`ifdef FIFO_FWFT_EN
    exp_d = (n != 0) ? int'(q[0]) : 0;
`else
    exp_d = int'(e_dout);
`endif
    chk("m_count", int'(bus.count), n);
    chk("m_full", int'(bus.full), int'(n == D));
    chk("m_empty", int'(bus.empty), int'(n == 0));
    chk("m_afull", int'(bus.almostfull), int'(n >= D - 1));
    chk("m_aempty", int'(bus.almostempty), int'(n <= 1));
    chk("m_wr_ack", int'(bus.wr_ack), int'(e_ack));
    chk("m_ovf", int'(bus.overflow), int'(e_ovf));
    chk("m_unf", int'(bus.underflow), int'(e_unf));
    chk("m_dout", int'(bus.data_out), exp_d);
  end

  task automatic step(input bit w, input bit r, input logic [W-1:0] d);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] exp_rd [8];

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_aempty", int'(bus.almostempty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_dout", int'(bus.data_out), 0);
    chk("rst_pulses", int'({bus.wr_ack, bus.overflow, bus.underflow}), 0);

    for (int i = 1; i <= 8; i++) begin
      step(1, 0, W'(i));
      chk("wr_ack_fill", int'(bus.wr_ack), 1);
      chk("afull_fill", int'(bus.almostfull), int'(i >= 7));
    end
    chk("full_at_8", int'(bus.full), 1);
    step(1, 0, 16'hDEAD);
    chk("ovf_9th", int'(bus.overflow), 1);
    chk("ack_9th", int'(bus.wr_ack), 0);
    chk("count_9th", int'(bus.count), 8);

    step(1, 1, 16'h00AA);
    chk("pt_count", int'(bus.count), 8);
    chk("pt_ovf", int'(bus.overflow), 0);
`ifdef FIFO_FWFT_EN
    chk("pt_dout", int'(bus.data_out), 16'h0002);
`else
    chk("pt_dout", int'(bus.data_out), 16'h0001);
`endif

    for (int i = 0; i < 7; i++) exp_rd[i] = W'(i + 2);
    exp_rd[7] = 16'h00AA;
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
      chk("rd_seq", int'(bus.data_out), int'(exp_rd[i]));
      step(0, 1, 0);
`else
      step(0, 1, 0);
      chk("rd_seq", int'(bus.data_out), int'(exp_rd[i]));
`endif
    end
    step(0, 1, 0);
    chk("unf_9th", int'(bus.underflow), 1);
    chk("cnt_drain", int'(bus.count), 0);

    step(1, 1, 16'h0BEE);
    chk("emp_rw_unf", int'(bus.underflow), 1);
    chk("emp_rw_cnt", int'(bus.count), 1);
    step(0, 1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, 0, W'(16'h100 * (r + 1) + i));
      for (int i = 0; i < 5; i++) step(0, 1, 0);
    end

    for (int i = 0; i < 2000; i++)
      step(1'($urandom), 1'($urandom), W'($urandom));

    while (bus.count != 0) step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, W'(16'h40 + i));
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_empty", int'(bus.empty), 1);
    chk("arst_dout", int'(bus.data_out), 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);

    step(1, 0, 16'h1234);
    bus.wr_en = 1'b0;
`ifdef FIFO_FWFT_EN
    chk("fwft_dout", int'(bus.data_out), 16'h1234);
`else
    chk("std_hold", int'(bus.data_out), 0);
`endif
    step(0, 1, 0);
    chk("final_cnt", int'(bus.count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
